// File: rtl/regwrite_hazard_ctrl_if.sv
// Decode <-> hazard controller bundle: issuing instruction fields in, stall/forward selects
// and the register file write port out.
interface regwrite_hazard_ctrl_if;
    logic       issue;
    logic       RegWrt;
    logic [4:0] Rd;
    logic [4:0] Rn;
    logic [4:0] Rm;
    logic       useRn;
    logic       useRm;
    logic       flush;
    logic       stall;
    logic [2:0] fwdA;
    logic [2:0] fwdB;
    logic       RegWrtO;
    logic [4:0] RdO;

    modport master (
        output issue, RegWrt, Rd, Rn, Rm, useRn, useRm, flush,
        input  stall, fwdA, fwdB, RegWrtO, RdO
    );

    modport slave (
        input  issue, RegWrt, Rd, Rn, Rm, useRn, useRm, flush,
        output stall, fwdA, fwdB, RegWrtO, RdO
    );
endinterface

// File: rtl/regwrite_hazard_ctrl.sv
// In-flight register-write tracker: stall / forward selection and regfile write port.
// Define HAZARD_STATS_EN to add saturating stallCount/fwdCount outputs.
module regwrite_hazard_ctrl #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned AVAIL_STAGE = 2,
    parameter int unsigned FLUSH_DEPTH = 1,
    parameter int unsigned ZERO_REG    = 31
) (
    input  logic                  clk,
    input  logic                  reset,
    regwrite_hazard_ctrl_if.slave bus
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]           stallCount,
    output logic [15:0]           fwdCount
`endif
);

    logic [DEPTH:1] valid;
    logic [DEPTH:1] wr;
    logic [4:0]     rd [1:DEPTH];

    logic [DEPTH:1] hitA, hitB;
    logic           stA, stB;
    logic [2:0]     fsA, fsB;
    logic           live;
    logic           stall_o;
    logic           accept;

    always_comb begin
        hitA = '0;
        hitB = '0;
        for (int unsigned k = 1; k <= DEPTH; k++) begin
            hitA[k] = valid[k] & wr[k] & (rd[k] == bus.Rn) & (bus.Rn != 5'(ZERO_REG)) & bus.useRn;
            hitB[k] = valid[k] & wr[k] & (rd[k] == bus.Rm) & (bus.Rm != 5'(ZERO_REG)) & bus.useRm;
        end
    end

    // Walk oldest to youngest so the youngest match overrides; stage DEPTH never forwards.
    always_comb begin
        stA = 1'b0;
        stB = 1'b0;
        fsA = '0;
        fsB = '0;
        for (int unsigned k = DEPTH - 1; k >= 1; k--) begin
            if (hitA[k]) begin
                stA = (k < AVAIL_STAGE);
                fsA = (k < AVAIL_STAGE) ? 3'd0 : 3'(k);
            end
            if (hitB[k]) begin
                stB = (k < AVAIL_STAGE);
                fsB = (k < AVAIL_STAGE) ? 3'd0 : 3'(k);
            end
        end
    end

    assign live        = bus.issue & ~bus.flush;
    assign stall_o     = live & (stA | stB);
    assign accept      = live & ~(stA | stB);
    assign bus.stall   = stall_o;
    assign bus.fwdA    = accept ? fsA : 3'd0;
    assign bus.fwdB    = accept ? fsB : 3'd0;
    assign bus.RegWrtO = valid[DEPTH] & wr[DEPTH];
    assign bus.RdO     = rd[DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            wr    <= '0;
            for (int unsigned k = 1; k <= DEPTH; k++) begin
                rd[k] <= '0;
            end
        end else begin
            // A flush squashes stages 1..FLUSH_DEPTH as they move down one slot.
            for (int unsigned k = 2; k <= DEPTH; k++) begin
                if (bus.flush && (k - 1) <= FLUSH_DEPTH) begin
                    valid[k] <= 1'b0;
                    wr[k]    <= 1'b0;
                    rd[k]    <= '0;
                end else begin
                    valid[k] <= valid[k-1];
                    wr[k]    <= wr[k-1];
                    rd[k]    <= rd[k-1];
                end
            end
            valid[1] <= accept;
            wr[1]    <= accept & bus.RegWrt;
            rd[1]    <= accept ? bus.Rd : 5'd0;
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCount <= '0;
            fwdCount   <= '0;
        end else begin
            if (stall_o && stallCount != '1) begin
                stallCount <= stallCount + 16'd1;
            end
            if (accept && (fsA != 3'd0 || fsB != 3'd0) && fwdCount != '1) begin
                fwdCount <= fwdCount + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_regwrite_hazard_ctrl.sv
// Bench for regwrite_hazard_ctrl: directed scenarios plus random traffic against a
// timeline model of accepted writes (HAZARD_STATS_EN adds counter checks).
module tb_regwrite_hazard_ctrl;
    localparam int DEPTH = 4;
    localparam int AVAIL = 2;
    localparam int FD    = 1;
    localparam int ZR    = 31;
    localparam int HN    = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regwrite_hazard_ctrl_if bus();

`ifdef HAZARD_STATS_EN
    logic [15:0] stallCount, fwdCount;
    logic [15:0] sStallCount, sFwdCount;
    logic        sreset;
    regwrite_hazard_ctrl_if sbus();
    regwrite_hazard_ctrl #(.DEPTH(7), .AVAIL_STAGE(6), .FLUSH_DEPTH(1), .ZERO_REG(31)) u_sat (
        .clk(clk), .reset(sreset), .bus(sbus),
        .stallCount(sStallCount), .fwdCount(sFwdCount)
    );
`endif

    regwrite_hazard_ctrl #(.DEPTH(DEPTH), .AVAIL_STAGE(AVAIL), .FLUSH_DEPTH(FD), .ZERO_REG(ZR)) dut (
        .clk(clk), .reset(reset), .bus(bus)
`ifdef HAZARD_STATS_EN
        , .stallCount(stallCount), .fwdCount(fwdCount)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Model: one record per clock edge holding the write accepted on that edge.
    bit       hv [HN];
    bit       hw [HN];
    int       hr [HN];
    int       n = 0;
    int       scnt = 0;
    int       fcnt = 0;
    logic       lo_stall, lo_wo;
    logic [2:0] lo_fa, lo_fb;
    logic [4:0] lo_rdo;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int slot(input int k);
        return (n - k + 1 + HN) % HN;
    endfunction

    function automatic void src_eval(input int s, input bit use_s, output bit st, output int fw);
        st = 0;
        fw = 0;
        if (use_s && s != ZR) begin
            for (int k = 1; k <= DEPTH; k++) begin
                if (hv[slot(k)] && hw[slot(k)] && hr[slot(k)] == s) begin
                    if (k < AVAIL) st = 1;
                    else if (k < DEPTH) fw = k;
                    break;
                end
            end
        end
    endfunction

    task automatic step(input bit iss, input bit wr, input int rd, input int rn, input int rm,
                        input bit urn, input bit urm, input bit fl, input bit rst);
        bit sa, sb, mst, acc;
        int fa, fb;
        @(negedge clk);
        reset      = rst;
        bus.issue  = iss;
        bus.RegWrt = wr;
        bus.Rd     = 5'(rd);
        bus.Rn     = 5'(rn);
        bus.Rm     = 5'(rm);
        bus.useRn  = urn;
        bus.useRm  = urm;
        bus.flush  = fl;
        #1;
        src_eval(rn, urn, sa, fa);
        src_eval(rm, urm, sb, fb);
        mst = iss && !fl && (sa || sb);
        acc = iss && !fl && !mst;
        if (!acc) begin
            fa = 0;
            fb = 0;
        end
        lo_stall = bus.stall;
        lo_fa    = bus.fwdA;
        lo_fb    = bus.fwdB;
        lo_wo    = bus.RegWrtO;
        lo_rdo   = bus.RdO;
        if (!rst) begin
            chk("stall", 16'(bus.stall), 16'(mst));
            if (!fl && !mst) begin
                chk("fwdA", 16'(bus.fwdA), 16'(fa));
                chk("fwdB", 16'(bus.fwdB), 16'(fb));
            end
            chk("RegWrtO", 16'(bus.RegWrtO), 16'(hv[slot(DEPTH)] && hw[slot(DEPTH)]));
            chk("RdO", 16'(bus.RdO), 16'(hr[slot(DEPTH)]));
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < HN; i++) begin
                hv[i] = 0; hw[i] = 0; hr[i] = 0;
            end
            scnt = 0;
            fcnt = 0;
            n++;
        end else begin
            if (mst && scnt < 65535) scnt++;
            if (acc && (fa != 0 || fb != 0) && fcnt < 65535) fcnt++;
            if (fl) begin
                for (int j = 0; j < FD; j++) begin
                    hv[slot(j + 1)] = 0; hw[slot(j + 1)] = 0; hr[slot(j + 1)] = 0;
                end
            end
            n++;
            hv[n % HN] = acc;
            hw[n % HN] = acc && wr;
            hr[n % HN] = (acc && wr) ? rd : 0;
            if (acc && !wr) hr[n % HN] = rd;
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit iss, wr, urn, urm, fl, rst;
        int rd, rn, rm;
        reset = 1'b1;
        bus.issue = 0; bus.RegWrt = 0; bus.Rd = 0; bus.Rn = 0; bus.Rm = 0;
        bus.useRn = 0; bus.useRm = 0; bus.flush = 0;
`ifdef HAZARD_STATS_EN
        sreset = 1'b1;
        sbus.issue = 0; sbus.RegWrt = 0; sbus.Rd = 0; sbus.Rn = 0; sbus.Rm = 0;
        sbus.useRn = 0; sbus.useRm = 0; sbus.flush = 0;
`endif
        for (int i = 0; i < HN; i++) begin
            hv[i] = 0; hw[i] = 0; hr[i] = 0;
        end

        // Reset for two cycles, then everything idle and zero.
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        chk("rst_stall", 16'(lo_stall), 16'd0);
        chk("rst_fwd", 16'({lo_fa, lo_fb}), 16'd0);
        chk("rst_wo", 16'(lo_wo), 16'd0);
        chk("rst_rdo", 16'(lo_rdo), 16'd0);

        // X5 reaches the write port in the 4th cycle after acceptance only.
        step(1, 1, 5, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            idle();
            chk("lat_wo", 16'(lo_wo), 16'(i == 4));
            chk("lat_rdo", 16'(lo_rdo), (i == 4) ? 16'd5 : 16'd0);
        end

        // Read of X3 right behind its write: one stall, then forward from stage 2.
        step(1, 1, 3, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 3, 0, 1, 0, 0, 0);
        chk("raw_stall", 16'(lo_stall), 16'd1);
        step(1, 0, 0, 3, 0, 1, 0, 0, 0);
        chk("raw_stall2", 16'(lo_stall), 16'd0);
        chk("raw_fwdA", 16'(lo_fa), 16'd2);
        repeat (4) idle();

        // Two writes to X7: the younger one is forwarded.
        step(1, 1, 7, 0, 0, 0, 0, 0, 0);
        step(1, 1, 7, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 7, 0, 1, 0, 0);
        chk("x7_stall", 16'(lo_stall), 16'd1);
        step(1, 0, 0, 0, 7, 0, 1, 0, 0);
        chk("x7_fwdB", 16'(lo_fb), 16'd2);
        repeat (4) idle();

        // XZR never hazards; a stage-DEPTH only match reads the regfile.
        step(1, 1, 31, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 31, 0, 1, 0, 0, 0);
        chk("xzr_stall", 16'(lo_stall), 16'd0);
        chk("xzr_fwdA", 16'(lo_fa), 16'd0);
        step(1, 1, 9, 0, 0, 0, 0, 0, 0);
        repeat (3) idle();
        step(1, 0, 0, 0, 9, 0, 1, 0, 0);
        chk("wb_stall", 16'(lo_stall), 16'd0);
        chk("wb_fwdB", 16'(lo_fb), 16'd0);
        chk("wb_rdo", 16'(lo_rdo), 16'd9);
        repeat (4) idle();

        // Flush squashes the just-accepted X4 and overrides the stall.
        step(1, 1, 4, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 4, 0, 1, 0, 1, 0);
        chk("fl_stall", 16'(lo_stall), 16'd0);
        for (int i = 0; i < 5; i++) begin
            idle();
            chk("fl_wo", 16'(lo_wo), 16'd0);
        end

        // Random traffic over a small register pool to provoke hazards.
        for (int i = 0; i < 1500; i++) begin
            iss = ($urandom_range(0, 9) < 8);
            wr  = $urandom_range(0, 1);
            urn = $urandom_range(0, 3) != 0;
            urm = $urandom_range(0, 3) != 0;
            fl  = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 149) == 0);
            rd  = $urandom_range(0, 4); if (rd == 4) rd = 31;
            rn  = $urandom_range(0, 4); if (rn == 4) rn = 31;
            rm  = $urandom_range(0, 4); if (rm == 4) rm = 31;
            step(iss, wr, rd, rn, rm, urn, urm, fl, rst);
        end

`ifdef HAZARD_STATS_EN
        chk("rnd_stallCount", stallCount, 16'(scnt));
        chk("rnd_fwdCount", fwdCount, 16'(fcnt));
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (3) begin
            step(1, 1, 3, 0, 0, 0, 0, 0, 0);
            step(1, 0, 0, 3, 0, 1, 0, 0, 0);
            step(1, 0, 0, 3, 0, 1, 0, 0, 0);
        end
        idle();
        chk("stallCount3", stallCount, 16'd3);
        chk("fwdCount3", fwdCount, 16'd3);

        // Saturation: write X1 then five stalled reads per period on a deep instance.
        @(negedge clk);
        sreset = 1'b0;
        for (int p = 0; p < 13108; p++) begin
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                sbus.issue  = 1'b1;
                sbus.RegWrt = (c == 0);
                sbus.Rd     = (c == 0) ? 5'd1 : 5'd0;
                sbus.Rn     = 5'd1;
                sbus.useRn  = (c != 0);
            end
        end
        @(negedge clk);
        sbus.issue = 1'b0;
        @(negedge clk);
        chk("stallCount_sat", sStallCount, 16'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
